// File: rtl/note_event_sequencer.sv
// Records timestamped key press/release events into a buffer and replays them with the same timing.
// Optional build macro LOOP_PLAYBACK_EN: playback restarts from the first event until stopped.
module note_event_sequencer #(
  parameter int NUM_KEYS = 8,
  parameter int DEPTH    = 256,
  parameter int MAX_TIME = 300000000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_KEYS-1:0]         keys,
  input  logic                        recordStart,
  input  logic                        playStart,
  input  logic                        stop,
  input  logic [28:0]                 microSecondCounter,
  output logic                        timerEnable,
  output logic [NUM_KEYS-1:0]         notesOut,
  output logic [$clog2(DEPTH):0]      eventCount,
  output logic                        overflow,
  output logic                        done
);
  localparam int KW = $clog2(NUM_KEYS);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = 29;
  localparam int EW = 1 + KW + TW;
  localparam logic [TW-1:0] WRAP = TW'(MAX_TIME + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       base_q, base_d;
  logic [NUM_KEYS-1:0] prev_keys_q, prev_keys_d;
  logic [NUM_KEYS-1:0] notes_q, notes_d;
  logic [AW:0]         count_q, count_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [EW-1:0]       mem_q [DEPTH];
  logic [EW-1:0]       rd_data_q;
  logic                wr_en;
  logic [TW-1:0]       elapsed;
  logic [NUM_KEYS-1:0] edges;
  logic                edge_found;
  logic [KW-1:0]       edge_key;

  // Modular 29-bit arithmetic gives the right answer across a single counter wrap.
  always_comb begin
    if (microSecondCounter >= base_q) elapsed = microSecondCounter - base_q;
    else                              elapsed = microSecondCounter - base_q + WRAP;
  end

  always_comb begin
    edges      = keys ^ prev_keys_q;
    edge_found = 1'b0;
    edge_key   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (edges[i]) begin
        edge_found = 1'b1;
        edge_key   = KW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      prev_keys_q <= '0;
      notes_q     <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      prev_keys_q <= prev_keys_d;
      notes_q     <= notes_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!stop && recordStart)    state_d = S_RECORD;
        else if (!stop && playStart) state_d = S_PLAY;
      end
      S_RECORD: if (stop) state_d = S_IDLE;
      S_PLAY: begin
        if (stop) state_d = S_IDLE;
        else if (rd_ptr_q == count_q) begin
`ifdef LOOP_PLAYBACK_EN
          if (count_q == '0) state_d = S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d      = base_q;
    prev_keys_d = prev_keys_q;
    notes_d     = notes_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!stop && recordStart) begin
          base_d      = microSecondCounter;
          count_d     = '0;
          overflow_d  = 1'b0;
          prev_keys_d = keys;
        end else if (!stop && playStart) begin
          base_d   = microSecondCounter;
          rd_ptr_d = '0;
          notes_d  = '0;
        end
      end
      S_RECORD: begin
        if (!stop && edge_found) begin
          prev_keys_d[edge_key] = keys[edge_key];
          if (count_q < (AW+1)'(DEPTH)) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (stop) begin
          notes_d = '0;
        end else if (rd_ptr_q == count_q) begin
          done_d  = 1'b1;
          notes_d = '0;
`ifdef LOOP_PLAYBACK_EN
          base_d   = microSecondCounter;
          rd_ptr_d = '0;
`endif
        end else if (elapsed >= rd_data_q[TW-1:0]) begin
          notes_d[rd_data_q[TW +: KW]] = rd_data_q[EW-1];
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Read address follows the next pointer, so rd_data_q always holds the entry at rd_ptr_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= {keys[edge_key], edge_key, elapsed};
    rd_data_q <= mem_q[rd_ptr_d[AW-1:0]];
  end

  assign timerEnable = (state_q != S_IDLE);
  assign notesOut    = notes_q;
  assign eventCount  = count_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
endmodule

// File: tb/tb_note_event_sequencer.sv
// Randomized and directed bench for note_event_sequencer against an event-list reference model.
module tb_note_event_sequencer;
  localparam int NK    = 8;
  localparam int DEPTH = 8;
  localparam int MAXT  = 300000000;

  logic          clk = 1'b0;
  logic          resetn, recordStart, playStart, stop;
  logic [NK-1:0] keys;
  logic [28:0]   now;
  logic          timerEnable, overflow, done;
  logic [NK-1:0] notesOut;
  logic [3:0]    eventCount;

  note_event_sequencer #(.NUM_KEYS(NK), .DEPTH(DEPTH), .MAX_TIME(MAXT)) dut (
    .clk(clk), .resetn(resetn), .keys(keys), .recordStart(recordStart),
    .playStart(playStart), .stop(stop), .microSecondCounter(now),
    .timerEnable(timerEnable), .notesOut(notesOut), .eventCount(eventCount),
    .overflow(overflow), .done(done));

  always #5 clk = ~clk;

  typedef struct {bit pressed; int key; int delta;} ev_t;
  ev_t       evq[$];
  bit        ovf_m;
  bit [NK-1:0] prev_m;
  bit [NK-1:0] notes_m;
  int        base_m;
  int        checks = 0;
  int        errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int elapsed(input int n, input int b);
    return (n >= b) ? n - b : n + MAXT + 1 - b;
  endfunction

  function automatic int adv(input int t, input int d);
    int r = t + d;
    if (r > MAXT) r -= MAXT + 1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_record(input int t);
    now = t; recordStart = 1'b1;
    base_m = t; evq.delete(); ovf_m = 1'b0; prev_m = keys;
    tick();
    recordStart = 1'b0;
    check("rec_start_te", timerEnable, 1);
    check("rec_start_cnt", eventCount, 0);
    check("rec_start_ovf", overflow, 0);
  endtask

  task automatic rec_cycle(input logic [NK-1:0] k, input int t);
    bit [NK-1:0] e;
    keys = k; now = t;
    e = k ^ prev_m;
    for (int i = 0; i < NK; i++) begin
      if (e[i]) begin
        if (evq.size() < DEPTH) evq.push_back(ev_t'{k[i], i, elapsed(t, base_m)});
        else ovf_m = 1'b1;
        prev_m[i] = k[i];
        break;
      end
    end
    tick();
    check("rec_cnt", eventCount, evq.size());
    check("rec_ovf", overflow, ovf_m);
    check("rec_te", timerEnable, 1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    notes_m = '0;
    check("stop_te", timerEnable, 0);
    check("stop_notes", notesOut, 0);
    check("stop_done", done, 0);
    check("stop_cnt", eventCount, evq.size());
  endtask

  task automatic play_run(input int t0, input int smin, input int smax, input int max_cycles);
    int t = t0;
    int idx = 0;
    bit fin = 1'b0;
    int te_exp = 0;
`ifdef LOOP_PLAYBACK_EN
    if (evq.size() > 0) te_exp = 1;
`endif
    now = t; playStart = 1'b1; base_m = t; notes_m = '0;
    tick();
    playStart = 1'b0;
    check("play_te", timerEnable, 1);
    for (int c = 0; c < max_cycles && !fin; c++) begin
      t = adv(t, int'($urandom_range(smax, smin)));
      now = t;
      if (idx == evq.size()) fin = 1'b1;
      else if (elapsed(t, base_m) >= evq[idx].delta) begin
        notes_m[evq[idx].key] = evq[idx].pressed;
        idx++;
      end
      tick();
      if (fin) begin
        check("play_done", done, 1);
        check("play_end_notes", notesOut, 0);
        check("play_end_te", timerEnable, te_exp);
      end else begin
        check("play_notes", notesOut, notes_m);
        check("play_nodone", done, 0);
      end
    end
    if (!fin) check("play_timeout", fin, 1);
  endtask

  initial begin
    int t;
    logic [NK-1:0] k;
    resetn = 1'b1; recordStart = 1'b0; playStart = 1'b0; stop = 1'b0;
    keys = '0; now = '0; notes_m = '0; evq.delete(); ovf_m = 1'b0;
    tick(); tick();
    check("rst_te", timerEnable, 0);
    check("rst_notes", notesOut, 0);
    check("rst_cnt", eventCount, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", done, 0);
    resetn = 1'b0;
    tick();

    // Priority: stop beats recordStart in IDLE
    stop = 1'b1; recordStart = 1'b1; now = 5;
    tick();
    stop = 1'b0; recordStart = 1'b0;
    check("prio_te", timerEnable, 0);
    tick();
    check("prio_te2", timerEnable, 0);

    // Empty playback finishes immediately
    play_run(100, 1, 1, 4);

    // Reference recording: key2 pressed at 1500, released at 2300, base 1000
    keys = '0;
    start_record(1000);
    rec_cycle(8'h00, 1200);
    rec_cycle(8'h04, 1500);
    rec_cycle(8'h04, 1800);
    rec_cycle(8'h00, 2300);
    do_stop();
    check("ref_cnt", eventCount, 2);
    play_run(50000, 100, 100, 40);
    do_stop();

    // Simultaneous edges at one timestamp
    keys = '0;
    start_record(7000);
    rec_cycle(8'b0010_1001, 7400);
    rec_cycle(8'b0010_1001, 7400);
    rec_cycle(8'b0010_1001, 7400);
    rec_cycle(8'b0010_1001, 7400);
    do_stop();
    play_run(9000, 50, 150, 40);
    do_stop();

    // Buffer full: more edges than entries
    keys = '0;
    start_record(20);
    for (int i = 0; i < 11; i++) rec_cycle(keys ^ (NK'(1) << (i % 3)), 30 + 10 * i);
    do_stop();
    check("full_cnt", eventCount, DEPTH);
    check("full_ovf", overflow, 1);
    play_run(500, 1, 5, 200);
    do_stop();
    check("full_ovf_kept", overflow, 1);

    // Wrap of the time counter during record and playback
    keys = '0;
    start_record(299999900);
    rec_cycle(8'h01, 99);
    do_stop();
    play_run(299999950, 100, 100, 10);
    do_stop();

    // Randomized record/playback sessions
    for (int it = 0; it < 25; it++) begin
      t = int'($urandom_range(MAXT, 0));
      start_record(t);
      k = keys;
      for (int c = 0; c < int'($urandom_range(14, 4)); c++) begin
        if ($urandom_range(2, 0) != 0) k[$urandom_range(NK-1, 0)] ^= 1'b1;
        if ($urandom_range(4, 0) == 0) k[$urandom_range(NK-1, 0)] ^= 1'b1;
        t = adv(t, int'($urandom_range(300, 0)));
        rec_cycle(k, t);
      end
      do_stop();
      play_run(int'($urandom_range(MAXT, 0)), 0, 300, 600);
      do_stop();
    end

    // Asynchronous reset in the middle of playback
    keys = '0;
    start_record(0);
    rec_cycle(8'h02, 10);
    rec_cycle(8'h00, 1000000);
    do_stop();
    now = 0; playStart = 1'b1;
    tick();
    playStart = 1'b0;
    for (int c = 0; c < 3; c++) begin
      now = 29'(100 * (c + 1));
      tick();
    end
    check("pre_rst_notes", notesOut, 8'h02);
    #2 resetn = 1'b1;
    #1;
    check("async_rst_notes", notesOut, 0);
    check("async_rst_cnt", eventCount, 0);
    check("async_rst_te", timerEnable, 0);
    evq.delete(); ovf_m = 1'b0; notes_m = '0;
    tick();
    resetn = 1'b0;
    tick();
    play_run(10, 1, 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
